// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider.
// FSM state codes and saturation constants.
package div_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t FIX  = 2'd2;

    localparam logic [15:0] MAX_POS = 16'h7FFF;
    localparam logic [15:0] MIN_NEG = 16'h8000;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on magnitudes:
// shift {rem,quo} left, trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);

    logic [WIDTH:0] sh;
    logic [WIDTH:0] trial;

    // keep the trial result when it is non-negative, else restore
    always_comb begin
        sh    = {rem, quo[WIDTH-1]};
        trial = sh - {1'b0, dvs};
        if (trial[WIDTH]) begin
            rem_nxt = sh[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b0};
        end else begin
            rem_nxt = trial[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/seq_div_16bit.sv
// Multi-cycle signed divider, one trial subtraction per cycle.
// Saturates MIN_NEG/-1 and divide-by-zero instead of trapping.
module seq_div_16bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             ovf
);

    import div_pkg::*;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quo_n;
    logic             neg_q;
    logic             neg_r;
    logic             spec;
    logic             dbz_r;
    logic             ovf_r;

    assign busy = (state != IDLE);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem_r),
        .quo     (quo_r),
        .dvs     (dvs_r),
        .rem_nxt (rem_n),
        .quo_nxt (quo_n)
    );

    // FSM, iteration counter and working registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            rem_r <= '0;
            quo_r <= '0;
            dvs_r <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            spec  <= 1'b0;
            dbz_r <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    neg_r <= dividend[WIDTH-1];
                    dvs_r <= divisor[WIDTH-1] ? -divisor : divisor;
                    cnt   <= '0;
                    if (divisor == '0) begin
                        // saturate toward the dividend's sign
                        spec  <= 1'b1;
                        dbz_r <= 1'b1;
                        ovf_r <= 1'b0;
                        quo_r <= dividend[WIDTH-1] ? MIN_NEG : MAX_POS;
                        rem_r <= dividend;
                        state <= FIX;
                    end else if (dividend == MIN_NEG && divisor == '1) begin
                        spec  <= 1'b1;
                        dbz_r <= 1'b0;
                        ovf_r <= 1'b1;
                        quo_r <= MAX_POS;
                        rem_r <= '0;
                        state <= FIX;
                    end else begin
                        spec  <= 1'b0;
                        dbz_r <= 1'b0;
                        ovf_r <= 1'b0;
                        quo_r <= dividend[WIDTH-1] ? -dividend : dividend;
                        rem_r <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    rem_r <= rem_n;
                    quo_r <= quo_n;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) state <= FIX;
                end
                FIX:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // sign fix-up and result registers; hold until next done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == FIX) begin
                done        <= 1'b1;
                div_by_zero <= dbz_r;
                ovf         <= ovf_r;
                if (spec) begin
                    quotient  <= quo_r;
                    remainder <= rem_r;
                end else begin
                    quotient  <= neg_q ? -quo_r : quo_r;
                    remainder <= neg_r ? -rem_r : rem_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_div_16bit.sv
// Directed-vector bench for seq_div_16bit.
// Expected quotients/remainders are hand-computed.
module tb_seq_div_16bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    seq_div_16bit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .ovf         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Launch now (just after an edge), wait for done, check all.
    // poke >= 0 pulses a second start that many cycles in.
    task automatic run(input string tag,
                       input logic [15:0] a,
                       input logic [15:0] b,
                       input logic [15:0] eq,
                       input logic [15:0] er,
                       input logic edz,
                       input logic eov,
                       input int elat,
                       input int poke);
        int n;
        bit bad;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n   = 0;
        bad = 1'b0;
        while (!done && n < 40) begin
            if (!busy) bad = 1'b1;
            if (n == poke) begin
                start    = 1'b1;
                dividend = 16'd999;
                divisor  = 16'd3;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
        end
        check({tag, "_lat"}, n, elat);
        check({tag, "_busy"}, {31'd0, bad}, 0);
        check({tag, "_q"}, {16'd0, quotient}, {16'd0, eq});
        check({tag, "_r"}, {16'd0, remainder}, {16'd0, er});
        check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edz});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eov});
        check({tag, "_idle"}, {31'd0, busy}, 0);
    endtask

    task automatic gap();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seen;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_q", {16'd0, quotient}, 0);
        check("rst_r", {16'd0, remainder}, 0);
        check("rst_flags", {30'd0, div_by_zero, ovf}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        gap();

        run("p_p", 16'd100, 16'd7, 16'h000E, 16'h0002, 0, 0, 17, -1);
        gap();
        run("n_p", 16'hFF9C, 16'd7, 16'hFFF2, 16'hFFFE, 0, 0, 17, -1);
        gap();
        run("p_n", 16'd100, 16'hFFF9, 16'hFFF2, 16'h0002, 0, 0, 17, -1);
        gap();
        run("n_n", 16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 0, 0, 17, -1);
        gap();
        run("ovf", 16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000, 0, 1, 1, -1);
        gap();
        run("min1", 16'h8000, 16'h0001, 16'h8000, 16'h0000, 0, 0, 17, -1);
        gap();
        run("max_min", 16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF, 0, 0, 17, -1);
        gap();
        run("min_min", 16'h8000, 16'h8000, 16'h0001, 16'h0000, 0, 0, 17, -1);
        gap();
        run("zero", 16'd0, 16'd5, 16'h0000, 16'h0000, 0, 0, 17, -1);
        gap();
        run("dz_p", 16'd5, 16'd0, 16'h7FFF, 16'h0005, 1, 0, 1, -1);
        gap();
        run("poke", 16'd1000, 16'd3, 16'h014D, 16'h0001, 0, 0, 17, 5);
        run("b2b", 16'd100, 16'd7, 16'h000E, 16'h0002, 0, 0, 17, -1);
        run("dz_n", 16'hFFFB, 16'd0, 16'h8000, 16'hFFFB, 1, 0, 1, -1);
        gap();

        dividend = 16'd100;
        divisor  = 16'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_q", {16'd0, quotient}, 0);
        check("abort_r", {16'd0, remainder}, 0);
        check("abort_flags", {30'd0, div_by_zero, ovf}, 0);
        seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("abort_nodone", seen, 0);
        run("after", 16'd100, 16'd7, 16'h000E, 16'h0002, 0, 0, 17, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
